// File: rtl/rv32i_instr_encoder_if.sv
// Request/write-port bundle between a program source and the RV32I instruction encoder.
// The master issues symbolic requests and observes the instruction-memory write port.
interface rv32i_instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4:0]            in_op;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic [31:0]           in_imm;
   logic                  in_last;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Assembles symbolic RV32I requests into machine words and streams them into
// instruction memory, one word per two cycles, starting at BASE_ADDR.
module rv32i_instr_encoder #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   rv32i_instr_encoder_if.slave  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   instr_count
);

   localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND   = 5'd2,  OP_OR   = 5'd3;
   localparam logic [4:0] OP_SLL  = 5'd4,  OP_SRL  = 5'd5,  OP_ADDI  = 5'd6,  OP_ANDI = 5'd7;
   localparam logic [4:0] OP_ORI  = 5'd8,  OP_SLLI = 5'd9,  OP_SRLI  = 5'd10, OP_LW   = 5'd11;
   localparam logic [4:0] OP_SW   = 5'd12, OP_BEQ  = 5'd13, OP_BNE   = 5'd14, OP_LUI  = 5'd15;
   localparam logic [4:0] OP_AUIPC = 5'd16, OP_JAL = 5'd17, OP_JALR  = 5'd18;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_e;

   // Returns {legal, word}; legality folds in both the op range and the immediate range.
   function automatic logic [32:0] f_encode(
      input logic [4:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      logic [31:0] w;
      logic        ok;
      logic        i_ok;
      logic        sh_ok;
      logic        b_ok;
      logic        j_ok;
      i_ok  = (imm[31:11] == 21'd0) || (imm[31:11] == {21{1'b1}});
      sh_ok = (imm[31:5] == 27'd0);
      b_ok  = ((imm[31:12] == 20'd0) || (imm[31:12] == {20{1'b1}})) && !imm[0];
      j_ok  = ((imm[31:20] == 12'd0) || (imm[31:20] == {12{1'b1}})) && !imm[0];
      w     = 32'd0;
      ok    = 1'b0;
      case (op)
         OP_ADD:   begin w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R}; ok = 1'b1; end
         OP_SUB:   begin w = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R}; ok = 1'b1; end
         OP_AND:   begin w = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R}; ok = 1'b1; end
         OP_OR:    begin w = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R}; ok = 1'b1; end
         OP_SLL:   begin w = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R}; ok = 1'b1; end
         OP_SRL:   begin w = {7'b0000000, rs2, rs1, 3'b101, rd, OPC_R}; ok = 1'b1; end
         OP_ADDI:  begin w = {imm[11:0], rs1, 3'b000, rd, OPC_I}; ok = i_ok; end
         OP_ANDI:  begin w = {imm[11:0], rs1, 3'b111, rd, OPC_I}; ok = i_ok; end
         OP_ORI:   begin w = {imm[11:0], rs1, 3'b110, rd, OPC_I}; ok = i_ok; end
         OP_SLLI:  begin w = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OPC_I}; ok = sh_ok; end
         OP_SRLI:  begin w = {7'b0000000, imm[4:0], rs1, 3'b101, rd, OPC_I}; ok = sh_ok; end
         OP_LW:    begin w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD}; ok = i_ok; end
         OP_SW:    begin w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE}; ok = i_ok; end
         OP_BEQ:   begin
            w  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
            ok = b_ok;
         end
         OP_BNE:   begin
            w  = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_BR};
            ok = b_ok;
         end
         OP_LUI:   begin w = {imm[31:12], rd, OPC_LUI}; ok = 1'b1; end
         OP_AUIPC: begin w = {imm[31:12], rd, OPC_AUIPC}; ok = 1'b1; end
         OP_JAL:   begin
            w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            ok = j_ok;
         end
         OP_JALR:  begin w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR}; ok = i_ok; end
         default:  begin w = 32'd0; ok = 1'b0; end
      endcase
      return {ok, w};
   endfunction

   state_e                r_state;
   state_e                w_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [31:0]           r_wdata;
   logic                  r_last;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_done;
   logic                  r_err;

   logic [32:0]           w_enc;
   logic                  w_legal;
   logic                  w_fire;
   logic                  w_full;
   logic                  w_can_start;

   assign w_enc       = f_encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
   assign w_legal     = w_enc[32];
   assign w_fire      = (r_state == S_LOAD) && bus.in_valid;
   assign w_full      = ((r_count + 1'b1) == DEPTH_C);
   assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LOAD;
         S_LOAD:                  if (bus.in_valid) w_next = w_legal ? S_WRITE : S_ERROR;
         S_WRITE:                 w_next = (r_last || w_full) ? S_DONE : S_LOAD;
         default:                 w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= BASE_C;
         r_wdata <= 32'd0;
         r_last  <= 1'b0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_can_start && start) begin
            r_ptr   <= BASE_C;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
         end
         if (w_fire) begin
            if (w_legal) begin
               r_wdata <= w_enc[31:0];
               r_last  <= bus.in_last;
            end else begin
               r_err   <= 1'b1;
            end
         end
         // The pointer wraps naturally at DEPTH; the count is one bit wider so it can show DEPTH.
         if (r_state == S_WRITE) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
            if (r_last || w_full) r_done <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = (r_state == S_LOAD);
   assign bus.imem_we    = (r_state == S_WRITE) && !rst;
   assign bus.imem_addr  = r_ptr;
   assign bus.imem_wdata = r_wdata;
   assign busy           = (r_state == S_LOAD) || (r_state == S_WRITE);
   assign done           = r_done;
   assign err            = r_err;
   assign instr_count    = r_count;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed program vectors, random requests
// against an arithmetic reference encoder, and a small-depth instance for wrap/full.
module tb_rv32i_instr_encoder;

   logic clk = 1'b0;
   logic rst;
   logic start_m, start_s;
   logic busy_m, done_m, err_m;
   logic busy_s, done_s, err_s;
   logic [8:0] cnt_m;
   logic [2:0] cnt_s;

   always #5 clk = ~clk;

   rv32i_instr_encoder_if #(.ADDR_WIDTH(8)) ifm ();
   rv32i_instr_encoder_if #(.ADDR_WIDTH(2)) ifs ();

   rv32i_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst(rst), .start(start_m), .bus(ifm.slave),
      .busy(busy_m), .done(done_m), .err(err_m), .instr_count(cnt_m)
   );

   rv32i_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_small (
      .clk(clk), .rst(rst), .start(start_s), .bus(ifs.slave),
      .busy(busy_s), .done(done_s), .err(err_s), .instr_count(cnt_s)
   );

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
      logic [8:0]  cnt;
   } exp_t;

   exp_t       q[$];
   int         n_checks = 0;
   int         n_errs   = 0;
   logic [7:0] m_ptr;
   int         m_count;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference encoder built from field weights and signed ranges.
   function automatic logic [32:0] ref_enc(input logic [4:0] op, input logic [4:0] rd5,
                                           input logic [4:0] rs15, input logic [4:0] rs25,
                                           input logic [31:0] imm);
      logic [31:0] rd, rs1, rs2, u, w, f3;
      int          s;
      bit          ok;
      rd  = 32'(rd5);
      rs1 = 32'(rs15);
      rs2 = 32'(rs25);
      s   = imm;
      ok  = 1'b1;
      w   = 32'd0;
      f3  = 32'd0;
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
            case (op)
               5'd2:    f3 = 32'd7;
               5'd3:    f3 = 32'd6;
               5'd4:    f3 = 32'd1;
               5'd5:    f3 = 32'd5;
               default: f3 = 32'd0;
            endcase
            w = ((op == 5'd1) ? 32'h4000_0000 : 32'd0) | (rs2 << 20) | (rs1 << 15)
              | (f3 << 12) | (rd << 7) | 32'h33;
         end
         5'd6, 5'd7, 5'd8, 5'd11, 5'd18: begin
            case (op)
               5'd7:    f3 = 32'd7;
               5'd8:    f3 = 32'd6;
               5'd11:   f3 = 32'd2;
               default: f3 = 32'd0;
            endcase
            ok = (s >= -2048) && (s <= 2047);
            w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
               | ((op == 5'd11) ? 32'h03 : (op == 5'd18) ? 32'h67 : 32'h13);
         end
         5'd9, 5'd10: begin
            ok = (imm < 32'd32);
            f3 = (op == 5'd9) ? 32'd1 : 32'd5;
            w  = ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         end
         5'd12: begin
            ok = (s >= -2048) && (s <= 2047);
            u  = imm & 32'hFFF;
            w  = ((u >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
               | ((u & 32'h1F) << 7) | 32'h23;
         end
         5'd13, 5'd14: begin
            ok = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
            u  = imm & 32'h1FFF;
            f3 = (op == 5'd14) ? 32'd1 : 32'd0;
            w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
               | (((u >> 11) & 32'h1) << 7) | 32'h63;
         end
         5'd15, 5'd16: begin
            w = (imm & 32'hFFFF_F000) | (rd << 7) | ((op == 5'd15) ? 32'h37 : 32'h17);
         end
         5'd17: begin
            ok = (s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0);
            u  = imm & 32'h1F_FFFF;
            w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
               | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
         end
         default: ok = 1'b0;
      endcase
      return {ok, w};
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (ifm.imem_we === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL unexpected_write: addr %0h data %0h with none pending",
                     ifm.imem_addr, ifm.imem_wdata);
         end else begin
            e = q.pop_front();
            chk("wr_addr",  64'(ifm.imem_addr),  64'(e.addr));
            chk("wr_data",  64'(ifm.imem_wdata), 64'(e.data));
            chk("wr_count", 64'(cnt_m),          64'(e.cnt));
         end
      end
   end

   task automatic chk_reset();
      chk("rst_ready", 64'(ifm.in_ready),   64'(0));
      chk("rst_we",    64'(ifm.imem_we),    64'(0));
      chk("rst_addr",  64'(ifm.imem_addr),  64'(0));
      chk("rst_wdata", 64'(ifm.imem_wdata), 64'(0));
      chk("rst_busy",  64'(busy_m),         64'(0));
      chk("rst_done",  64'(done_m),         64'(0));
      chk("rst_err",   64'(err_m),          64'(0));
      chk("rst_count", 64'(cnt_m),          64'(0));
   endtask

   task automatic do_start();
      start_m = 1'b1;
      @(posedge clk);
      #1;
      start_m = 1'b0;
      m_ptr   = 8'd0;
      m_count = 0;
      chk("start_busy",  64'(busy_m),        64'(1));
      chk("start_err",   64'(err_m),         64'(0));
      chk("start_done",  64'(done_m),        64'(0));
      chk("start_count", 64'(cnt_m),         64'(0));
      chk("start_addr",  64'(ifm.imem_addr), 64'(0));
   endtask

   task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input bit last,
                       input bit use_hex, input logic [31:0] hex, input bit exp_wr);
      logic [32:0] r;
      logic [31:0] word;
      bit          legal;
      int          waitc;
      r     = ref_enc(op, rd, rs1, rs2, imm);
      legal = r[32];
      word  = use_hex ? hex : r[31:0];
      ifm.in_op    = op;
      ifm.in_rd    = rd;
      ifm.in_rs1   = rs1;
      ifm.in_rs2   = rs2;
      ifm.in_imm   = imm;
      ifm.in_last  = last;
      ifm.in_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!ifm.in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!ifm.in_ready) begin
         chk("ready_timeout", 64'(ifm.in_ready), 64'(1));
         ifm.in_valid = 1'b0;
         return;
      end
      if (legal && exp_wr) q.push_back({m_ptr, word, m_count[8:0]});
      @(posedge clk);
      #1;
      ifm.in_valid = 1'b0;
      if (!legal) begin
         chk("err_set",   64'(err_m),        64'(1));
         chk("err_busy",  64'(busy_m),       64'(0));
         chk("err_ready", 64'(ifm.in_ready), 64'(0));
         return;
      end
      m_ptr++;
      m_count++;
      if (last || m_count == 256) begin
         @(posedge clk);
         #1;
         chk("done_set",   64'(done_m),       64'(1));
         chk("done_busy",  64'(busy_m),       64'(0));
         chk("done_ready", 64'(ifm.in_ready), 64'(0));
         chk("done_count", 64'(cnt_m),        64'(m_count));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          op;
      int          n_wr;
      int          n_acc;
      logic [31:0] imm;
      logic [31:0] w7;
      logic [32:0] r7;
      rst = 1'b1;
      start_m = 1'b0;
      start_s = 1'b0;
      ifm.in_valid = 1'b0; ifm.in_op = '0; ifm.in_rd = '0; ifm.in_rs1 = '0;
      ifm.in_rs2 = '0; ifm.in_imm = '0; ifm.in_last = 1'b0;
      ifs.in_valid = 1'b0; ifs.in_op = '0; ifs.in_rd = '0; ifs.in_rs1 = '0;
      ifs.in_rs2 = '0; ifs.in_imm = '0; ifs.in_last = 1'b0;
      m_ptr = 8'd0;
      m_count = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset();

      do_start();
      send(5'd6, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h0050_0093, 1'b1);

      do_start();
      send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020_81B3, 1'b1);
      send(5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h4020_81B3, 1'b1);

      do_start();
      send(5'd12, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 1'b1, 32'h0020_A423, 1'b1);
      send(5'd13, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  1'b0, 1'b1, 32'hFE20_8EE3, 1'b1);
      send(5'd17, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 1'b1, 32'h0080_00EF, 1'b1);
      send(5'd15, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  1'b1, 1'b1, 32'h1234_52B7, 1'b1);

      do_start();
      send(5'd6, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0, 1'b1);
      do_start();
      send(5'd25, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      do_start();
      send(5'd13, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1);
      do_start();
      send(5'd6, 5'd2, 5'd1, 5'd0, 32'hFFFF_F800, 1'b1, 1'b0, 32'd0, 1'b1);

      // Reset in the middle of a write: the pulse must vanish and the session restart at 0.
      do_start();
      send(5'd6, 5'd1, 5'd0, 5'd0, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_write_we", 64'(ifm.imem_we), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset();
      do_start();
      send(5'd7, 5'd4, 5'd3, 5'd0, 32'd15, 1'b1, 1'b0, 32'd0, 1'b1);

      do_start();
      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 19));
         if (op == 19) op = int'($urandom_range(19, 31));
         case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($signed(int'($urandom_range(0, 4095)) - 2048));
            2:       imm = 32'($urandom_range(0, 63));
            default: imm = 32'($signed(int'($urandom_range(0, 8191)) - 4096)) & 32'hFFFF_FFFE;
         endcase
         send(5'(op), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), imm, ($urandom_range(0, 9) == 0) || (i == 79),
              1'b0, 32'd0, 1'b1);
         if (!busy_m) do_start();
      end
      @(negedge clk);
      @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'(0));

      // Depth-4 instance: requests kept valid must stop after the memory is full.
      r7 = ref_enc(5'd6, 5'd1, 5'd0, 5'd0, 32'd7);
      w7 = r7[31:0];
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      ifs.in_op = 5'd6; ifs.in_rd = 5'd1; ifs.in_rs1 = 5'd0; ifs.in_rs2 = 5'd0;
      ifs.in_imm = 32'd7; ifs.in_last = 1'b0; ifs.in_valid = 1'b1;
      n_wr = 0;
      n_acc = 0;
      repeat (14) begin
         @(negedge clk);
         if (ifs.in_valid && ifs.in_ready) n_acc++;
         if (ifs.imem_we) begin
            chk("small_addr", 64'(ifs.imem_addr),  64'(n_wr));
            chk("small_data", 64'(ifs.imem_wdata), 64'(w7));
            n_wr++;
         end
      end
      ifs.in_valid = 1'b0;
      chk("small_writes", 64'(n_wr),         64'(4));
      chk("small_accept", 64'(n_acc),        64'(4));
      chk("small_done",   64'(done_s),       64'(1));
      chk("small_count",  64'(cnt_s),        64'(4));
      chk("small_ready",  64'(ifs.in_ready), 64'(0));
      chk("small_err",    64'(err_s),        64'(0));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Inverse of the core's instruction decoder. It accepts symbolic RV32I instruction requests (operation, register indices, immediate) over a valid/ready handshake and assembles the 32-bit machine word. It then writes the word sequentially into instruction memory through a write port. The bench, boot loader and self-test sequencer use it to load programs into the pipeline's instruction memory without a precompiled hex image.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory; depth DEPTH = 2**ADDR_WIDTH words.
BASE_ADDR, 0, word address of the first instruction written after start.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a new load session; pointer and count reset to zero
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
in_op  in  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 ADDI, 7 ANDI, 8 ORI, 9 SLLI, 10 SRLI, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 LUI, 16 AUIPC, 17 JAL, 18 JALR; 19-31 illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate or byte offset
in_last  in  1  this request ends the program
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_WIDTH  word write address
imem_wdata  out  32  encoded instruction
busy  out  1  state is LOAD or WRITE
done  out  1  session finished normally (sticky)
err  out  1  illegal op or immediate out of range (sticky)
instr_count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, instr_count 0.
- FSM states: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE, DONE, ERROR:
  - in_ready is 0.
  - start moves the FSM to LOAD next cycle and clears pointer (to BASE_ADDR), instr_count, done and err.
- LOAD: in_ready = 1. On in_valid & in_ready, the request is encoded and checked in the same cycle.
  - Legal request: imem_wdata, imem_addr and the last flag are registered, and the FSM goes to WRITE.
  - Illegal request: err is set, nothing is written, and the FSM goes to ERROR.
- WRITE: lasts exactly one cycle.
  - imem_we = (state==WRITE) & !rst; in_ready = 0. Throughput is one instruction per 2 cycles; write latency is 1 cycle after acceptance.
  - Next edge: pointer +1 (wraps modulo DEPTH) and instr_count +1.
  - If the captured last flag is set, or instr_count reaches DEPTH, done is set and the FSM goes to DONE; otherwise it returns to LOAD.
- start is ignored in LOAD and WRITE.
- rst in any state, including during WRITE, returns every output to its reset value at that edge. The write presented in that cycle is suppressed.
- Encoding formats, field order MSB to LSB:
  - R-type: {f7, rs2, rs1, f3, rd, 0110011}. f3 values: ADD/SUB 000, SLL 001, SRL 101, OR 110, AND 111. f7 is 0100000 for SUB, else 0000000.
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}. SLLI/SRLI use {0000000, imm[4:0]} as the upper field.
  - LW: I-format, f3 010, opcode 0000011.
  - JALR: I-format, f3 000, opcode 1100111.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BEQ/BNE: {imm[12], imm[10:5], rs2, rs1, f3 000/001, imm[4:1], imm[11], 1100011}.
  - LUI/AUIPC: {imm[31:12], rd, 0110111/0010111}; imm[11:0] is ignored.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
- Range checks (any failure sets err):
  - I, S and JALR immediates: imm[31:11] all equal.
  - Shift immediates: imm[31:5] == 0.
  - Branch immediates: imm[31:12] all equal and imm[0] == 0.
  - JAL immediates: imm[31:20] all equal and imm[0] == 0.
  - Op codes 19-31 are illegal.
- Unused register fields are ignored: rs1/rs2 for U/J, rs2 for I, rd for S/B.

Test Plan:
- Reset, start; ADDI rd1 rs1=0 imm5 → one cycle after handshake: imem_we=1, addr 0, wdata 0x00500093; instr_count 1.
- ADD x3,x1,x2 then SUB x3,x1,x2 (last) → 0x002081B3 at addr 0, 0x402081B3 at addr 1; done=1, instr_count 2, in_ready 0.
- SW x2,8(x1) → 0x0020A423; BEQ x1,x2,imm -4 → 0xFE208EE3; JAL x1,imm 8 → 0x008000EF; LUI x5,imm 0x12345000 → 0x123452B7.
- ADDI imm 2048 (also: op 25, BEQ imm 3) → err=1, no imem_we pulse, state ERROR; a following start clears err and the next write lands at addr 0.
- ADDR_WIDTH=2: 5 requests without last → 4 writes at addrs 0-3, done after the 4th, instr_count 4, the 5th is never accepted.
- rst high during WRITE → imem_we=0 that cycle, all outputs at reset values; start then resumes from addr 0.
